// File: rtl/dm_access_if.sv
// Request/response bus between the MEM stage (master) and the data-memory
// access controller (slave). Valid/ready handshake on the request side and
// a single-cycle response pulse on the return side.
interface dm_access_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/dm_access_ctrl.sv
// Data-memory access controller. Sequences MEM-stage loads/stores onto a
// single-port synchronous SRAM (1-cycle read latency, active-low CEB/WEB/BWEB).
// Performs byte-lane steering, store masking and load sign/zero extension.
// A misaligned access that crosses a word boundary is issued as two aligned
// beats (word wa, then wa+1 modulo 2^ADDR_W).
//
// Build option: define DM_MISALIGN_TRAP_EN to reject any access whose byte
// offset is not a multiple of its size. A rejected access issues no SRAM beat
// and returns rsp_err=1 one cycle after accept. Without the macro rsp_err is 0.
module dm_access_ctrl #(
    parameter int ADDR_W = 14
) (
    input  logic              clk,
    input  logic              rst,
    dm_access_if.slave        bus,
    output logic              sram_ceb,
    output logic              sram_web,
    output logic [31:0]       sram_bweb,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [31:0]       sram_din,
    input  logic [31:0]       sram_dout
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BEAT0 = 2'd1,
        BEAT1 = 2'd2,
        FIN   = 2'd3
    } state_t;

    state_t state_q, state_d;

    // Captured request. size_q holds the normalised size: 0=byte, 1=half, 2=word.
    logic              wr_q;
    logic              uns_q;
    logic [1:0]        size_q;
    logic [1:0]        off_q;
    logic [ADDR_W-1:0] wa_q;
    logic              split_q;
    logic [31:0]       wdata_q;
    logic [31:0]       lo_buf_q;
`ifdef DM_MISALIGN_TRAP_EN
    logic              err_q;
`endif

    // Request decode (only meaningful at accept).
    logic              accept;
    logic [1:0]        req_off;
    logic [1:0]        req_sz;
    logic [2:0]        req_nbytes;
    logic              req_split;
    logic              req_misalign;

    // Byte address bits above the SRAM word address are deliberately ignored.
    logic              unused_addr_hi;
    assign unused_addr_hi = ^bus.req_addr[31:ADDR_W+2];

    // Datapath.
    logic [4:0]        shamt;
    logic [63:0]       lane64;
    logic [63:0]       mask_base;
    logic [63:0]       mask64;
    logic [63:0]       rd64;
    logic [31:0]       sel;
    logic [31:0]       load_data;

    assign accept = (state_q == IDLE) && bus.req_valid;

    // Decode size/offset of the incoming request and detect word-crossing.
    always_comb begin
        // NOTE: every signal written here gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        req_off      = bus.req_addr[1:0];
        req_sz       = 2'd2;
        req_nbytes   = 3'd4;
        req_misalign = 1'b0;
        case (bus.req_size)
            2'd0: begin
                req_sz     = 2'd0;
                req_nbytes = 3'd1;
            end
            2'd1: begin
                req_sz       = 2'd1;
                req_nbytes   = 3'd2;
                req_misalign = req_off[0];
            end
            default: begin
                req_sz       = 2'd2;
                req_nbytes   = 3'd4;
                req_misalign = (req_off != 2'd0);
            end
        endcase
        req_split = (({1'b0, req_off} + req_nbytes) > 3'd4);
    end

    // State and request registers; capture on accept, low beat on BEAT1 loads.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (rst) begin
            state_q  <= IDLE;
            wr_q     <= 1'b0;
            uns_q    <= 1'b0;
            size_q   <= 2'd0;
            off_q    <= 2'd0;
            wa_q     <= '0;
            split_q  <= 1'b0;
            wdata_q  <= 32'd0;
            lo_buf_q <= 32'd0;
`ifdef DM_MISALIGN_TRAP_EN
            err_q    <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            if (accept) begin
                wr_q    <= bus.req_write;
                uns_q   <= bus.req_unsigned;
                size_q  <= req_sz;
                off_q   <= req_off;
                wa_q    <= bus.req_addr[ADDR_W+1:2];
                split_q <= req_split;
                wdata_q <= bus.req_wdata;
`ifdef DM_MISALIGN_TRAP_EN
                err_q   <= req_misalign;
`endif
            end
            if ((state_q == BEAT1) && !wr_q) begin
                lo_buf_q <= sram_dout;
            end
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
`ifdef DM_MISALIGN_TRAP_EN
                    state_d = req_misalign ? FIN : BEAT0;
`else
                    state_d = BEAT0;
`endif
                end
            end
            BEAT0:   state_d = split_q ? BEAT1 : FIN;
            BEAT1:   state_d = FIN;
            default: state_d = IDLE;
        endcase
    end

    // Lane steering for stores and alignment/extension for loads.
    always_comb begin
        shamt  = {off_q, 3'b000};
        lane64 = {32'd0, wdata_q} << shamt;
        case (size_q)
            2'd0:    mask_base = 64'h0000_0000_0000_00FF;
            2'd1:    mask_base = 64'h0000_0000_0000_FFFF;
            default: mask_base = 64'h0000_0000_FFFF_FFFF;
        endcase
        mask64 = mask_base << shamt;
        rd64   = split_q ? {sram_dout, lo_buf_q} : {32'd0, sram_dout};
        sel    = rd64[shamt +: 32];
        case (size_q)
            2'd0:    load_data = uns_q ? {24'd0, sel[7:0]}   : {{24{sel[7]}}, sel[7:0]};
            2'd1:    load_data = uns_q ? {16'd0, sel[15:0]}  : {{16{sel[15]}}, sel[15:0]};
            default: load_data = sel;
        endcase
    end

    // SRAM and response outputs; idle values outside beats and during reset.
    always_comb begin
        sram_ceb      = 1'b1;
        sram_web      = 1'b1;
        sram_bweb     = '1;
        sram_addr     = '0;
        sram_din      = 32'd0;
        bus.rsp_valid = 1'b0;
        bus.rsp_rdata = 32'd0;
        bus.rsp_err   = 1'b0;
        bus.req_ready = 1'b0;
        if (!rst) begin
            case (state_q)
                IDLE: bus.req_ready = 1'b1;
                BEAT0: begin
                    sram_ceb  = 1'b0;
                    sram_addr = wa_q;
                    if (wr_q) begin
                        sram_web  = 1'b0;
                        sram_din  = lane64[31:0];
                        sram_bweb = ~mask64[31:0];
                    end
                end
                BEAT1: begin
                    sram_ceb  = 1'b0;
                    sram_addr = wa_q + ADDR_W'(1);
                    if (wr_q) begin
                        sram_web  = 1'b0;
                        sram_din  = lane64[63:32];
                        sram_bweb = ~mask64[63:32];
                    end
                end
                default: begin
                    bus.rsp_valid = 1'b1;
                    bus.rsp_rdata = wr_q ? 32'd0 : load_data;
`ifdef DM_MISALIGN_TRAP_EN
                    if (err_q) begin
                        bus.rsp_err   = 1'b1;
                        bus.rsp_rdata = 32'd0;
                    end
`endif
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dm_access_ctrl.sv
// Directed self-checking bench for dm_access_ctrl with a behavioural
// single-port SRAM (1-cycle read latency, per-bit active-low write mask).
// Expected values are hand-computed; tests adapt when DM_MISALIGN_TRAP_EN
// is defined.
module tb_dm_access_ctrl;
    localparam int ADDR_W = 14;

    logic              clk;
    logic              rst;
    logic              sram_ceb;
    logic              sram_web;
    logic [31:0]       sram_bweb;
    logic [ADDR_W-1:0] sram_addr;
    logic [31:0]       sram_din;
    logic [31:0]       sram_dout;

    logic [31:0]       mem [0:(1<<ADDR_W)-1];
    logic              pl_en;
    logic [ADDR_W-1:0] pl_addr;
    logic [31:0]       pl_data;

    int checks;
    int errors;

    dm_access_if bus_if ();

    dm_access_ctrl #(.ADDR_W(ADDR_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus_if),
        .sram_ceb  (sram_ceb),
        .sram_web  (sram_web),
        .sram_bweb (sram_bweb),
        .sram_addr (sram_addr),
        .sram_din  (sram_din),
        .sram_dout (sram_dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // SRAM model with a bench-side preload port.
    always @(posedge clk) begin
        if (pl_en) begin
            mem[pl_addr] <= pl_data;
        end else if (!sram_ceb) begin
            if (!sram_web) mem[sram_addr] <= (mem[sram_addr] & sram_bweb) | (sram_din & ~sram_bweb);
            else           sram_dout <= mem[sram_addr];
        end
    end

    task automatic preload(input logic [ADDR_W-1:0] a, input logic [31:0] d);
        @(negedge clk);
        pl_en = 1'b1; pl_addr = a; pl_data = d;
        @(posedge clk);
        #1 pl_en = 1'b0;
    endtask

    // Present a request at a negedge; returns 1 time unit after the accept edge.
    task automatic send(input logic wr, input logic [1:0] sz, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wd, input logic hold);
        @(negedge clk);
        bus_if.req_valid    = 1'b1;
        bus_if.req_write    = wr;
        bus_if.req_size     = sz;
        bus_if.req_unsigned = uns;
        bus_if.req_addr     = addr;
        bus_if.req_wdata    = wd;
        @(posedge clk);
        #1;
        if (!hold) bus_if.req_valid = 1'b0;
        bus_if.req_write    = ~wr;
        bus_if.req_size     = ~sz;
        bus_if.req_unsigned = ~uns;
        bus_if.req_addr     = ~addr;
        bus_if.req_wdata    = ~wd;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++; if (bus_if.req_ready !== 1'b0) begin errors++; $display("FAIL rst req_ready: got %b want 0", bus_if.req_ready); end
        checks++; if (bus_if.rsp_valid !== 1'b0) begin errors++; $display("FAIL rst rsp_valid: got %b want 0", bus_if.rsp_valid); end
        checks++; if (bus_if.rsp_rdata !== 32'd0) begin errors++; $display("FAIL rst rsp_rdata: got %h want 0", bus_if.rsp_rdata); end
        checks++; if (bus_if.rsp_err !== 1'b0) begin errors++; $display("FAIL rst rsp_err: got %b want 0", bus_if.rsp_err); end
        checks++; if ({sram_ceb, sram_web} !== 2'b11) begin errors++; $display("FAIL rst ceb/web: got %b want 11", {sram_ceb, sram_web}); end
        checks++; if (sram_bweb !== 32'hFFFF_FFFF) begin errors++; $display("FAIL rst bweb: got %h want ffffffff", sram_bweb); end
        checks++; if (sram_addr !== '0 || sram_din !== 32'd0) begin errors++; $display("FAIL rst addr/din: got %h/%h want 0/0", sram_addr, sram_din); end
        rst = 1'b0;
        #1;
        checks++; if (bus_if.req_ready !== 1'b1) begin errors++; $display("FAIL rst release req_ready: got %b want 1", bus_if.req_ready); end
    endtask

    task automatic test_word_store;
        send(1'b1, 2'd2, 1'b0, 32'h0000_0100, 32'hDEAD_BEEF, 1'b0);
        @(negedge clk);
        checks++; if ({sram_ceb, sram_web} !== 2'b00) begin errors++; $display("FAIL st_w ceb/web: got %b want 00", {sram_ceb, sram_web}); end
        checks++; if (sram_addr !== 14'h0040) begin errors++; $display("FAIL st_w addr: got %h want 0040", sram_addr); end
        checks++; if (sram_bweb !== 32'h0000_0000) begin errors++; $display("FAIL st_w bweb: got %h want 00000000", sram_bweb); end
        checks++; if (sram_din !== 32'hDEAD_BEEF) begin errors++; $display("FAIL st_w din: got %h want deadbeef", sram_din); end
        checks++; if (bus_if.req_ready !== 1'b0) begin errors++; $display("FAIL st_w busy ready: got %b want 0", bus_if.req_ready); end
        @(negedge clk);
        checks++; if (bus_if.rsp_valid !== 1'b1) begin errors++; $display("FAIL st_w rsp_valid: got %b want 1", bus_if.rsp_valid); end
        checks++; if (bus_if.rsp_rdata !== 32'd0 || bus_if.rsp_err !== 1'b0) begin errors++; $display("FAIL st_w rdata/err: got %h/%b want 0/0", bus_if.rsp_rdata, bus_if.rsp_err); end
        checks++; if (sram_ceb !== 1'b1) begin errors++; $display("FAIL st_w fin ceb: got %b want 1", sram_ceb); end
        @(negedge clk);
        checks++; if (bus_if.rsp_valid !== 1'b0 || bus_if.req_ready !== 1'b1) begin errors++; $display("FAIL st_w after valid/ready: got %b/%b want 0/1", bus_if.rsp_valid, bus_if.req_ready); end
        checks++; if (mem[14'h0040] !== 32'hDEAD_BEEF) begin errors++; $display("FAIL st_w mem: got %h want deadbeef", mem[14'h0040]); end
    endtask

    task automatic test_byte_load;
        logic [31:0] exp_rd [2];
        exp_rd[0] = 32'hFFFF_FF80;
        exp_rd[1] = 32'h0000_0080;
        preload(14'h0040, 32'h8011_2233);
        for (int u = 0; u < 2; u++) begin
            send(1'b0, 2'd0, u[0], 32'h0000_0103, 32'd0, 1'b0);
            @(negedge clk);
            checks++; if ({sram_ceb, sram_web} !== 2'b01 || sram_addr !== 14'h0040) begin errors++; $display("FAIL ld_b%0d beat: got ceb/web %b addr %h want 01 0040", u, {sram_ceb, sram_web}, sram_addr); end
            @(negedge clk);
            checks++; if (bus_if.rsp_valid !== 1'b1 || bus_if.rsp_rdata !== exp_rd[u]) begin errors++; $display("FAIL ld_b%0d rsp: got %b %h want 1 %h", u, bus_if.rsp_valid, bus_if.rsp_rdata, exp_rd[u]); end
            @(negedge clk);
        end
    endtask

    task automatic test_half_store_masked;
        preload(14'h0050, 32'h1122_3344);
        send(1'b1, 2'd1, 1'b0, 32'h0000_0142, 32'h9999_ABCD, 1'b0);
        @(negedge clk);
        checks++; if (sram_addr !== 14'h0050 || sram_bweb !== 32'h0000_FFFF || sram_din !== 32'hABCD_0000) begin errors++; $display("FAIL st_h beat: got %h %h %h want 0050 0000ffff abcd0000", sram_addr, sram_bweb, sram_din); end
        @(negedge clk);
        checks++; if (bus_if.rsp_valid !== 1'b1) begin errors++; $display("FAIL st_h rsp_valid: got %b want 1", bus_if.rsp_valid); end
        @(negedge clk);
        checks++; if (mem[14'h0050] !== 32'hABCD_3344) begin errors++; $display("FAIL st_h mem: got %h want abcd3344", mem[14'h0050]); end
    endtask

    task automatic test_split_store;
        preload(14'h003F, 32'h1111_1111);
        preload(14'h0040, 32'h2222_2222);
        send(1'b1, 2'd1, 1'b0, 32'h0000_00FF, 32'h0000_ABCD, 1'b0);
`ifdef DM_MISALIGN_TRAP_EN
        @(negedge clk);
        checks++; if (sram_ceb !== 1'b1) begin errors++; $display("FAIL st_split trap ceb: got %b want 1", sram_ceb); end
        checks++; if (bus_if.rsp_valid !== 1'b1 || bus_if.rsp_err !== 1'b1 || bus_if.rsp_rdata !== 32'd0) begin errors++; $display("FAIL st_split trap rsp: got %b %b %h want 1 1 0", bus_if.rsp_valid, bus_if.rsp_err, bus_if.rsp_rdata); end
        @(negedge clk);
        checks++; if (bus_if.req_ready !== 1'b1 || bus_if.rsp_valid !== 1'b0) begin errors++; $display("FAIL st_split trap after: got ready %b valid %b want 1 0", bus_if.req_ready, bus_if.rsp_valid); end
        checks++; if (mem[14'h003F] !== 32'h1111_1111) begin errors++; $display("FAIL st_split trap mem: got %h want 11111111", mem[14'h003F]); end
`else
        @(negedge clk);
        checks++; if ({sram_ceb, sram_web} !== 2'b00 || sram_addr !== 14'h003F) begin errors++; $display("FAIL st_split b0 ctl: got %b %h want 00 003f", {sram_ceb, sram_web}, sram_addr); end
        checks++; if (sram_bweb !== 32'h00FF_FFFF || sram_din !== 32'hCD00_0000) begin errors++; $display("FAIL st_split b0 data: got %h %h want 00ffffff cd000000", sram_bweb, sram_din); end
        @(negedge clk);
        checks++; if ({sram_ceb, sram_web} !== 2'b00 || sram_addr !== 14'h0040) begin errors++; $display("FAIL st_split b1 ctl: got %b %h want 00 0040", {sram_ceb, sram_web}, sram_addr); end
        checks++; if (sram_bweb !== 32'hFFFF_FF00 || sram_din !== 32'h0000_00AB) begin errors++; $display("FAIL st_split b1 data: got %h %h want ffffff00 000000ab", sram_bweb, sram_din); end
        checks++; if (bus_if.rsp_valid !== 1'b0) begin errors++; $display("FAIL st_split early valid: got %b want 0", bus_if.rsp_valid); end
        @(negedge clk);
        checks++; if (bus_if.rsp_valid !== 1'b1 || bus_if.rsp_rdata !== 32'd0) begin errors++; $display("FAIL st_split rsp: got %b %h want 1 0", bus_if.rsp_valid, bus_if.rsp_rdata); end
        @(negedge clk);
        checks++; if (mem[14'h003F] !== 32'hCD11_1111 || mem[14'h0040] !== 32'h2222_22AB) begin errors++; $display("FAIL st_split mem: got %h %h want cd111111 222222ab", mem[14'h003F], mem[14'h0040]); end
`endif
    endtask

    task automatic test_split_load;
        preload(14'h0040, 32'h4433_2211);
        preload(14'h0041, 32'h8877_6655);
        send(1'b0, 2'd2, 1'b0, 32'h0000_0102, 32'd0, 1'b0);
`ifdef DM_MISALIGN_TRAP_EN
        @(negedge clk);
        checks++; if (sram_ceb !== 1'b1 || bus_if.rsp_valid !== 1'b1 || bus_if.rsp_err !== 1'b1 || bus_if.rsp_rdata !== 32'd0) begin errors++; $display("FAIL ld_split trap: got ceb %b valid %b err %b rdata %h want 1 1 1 0", sram_ceb, bus_if.rsp_valid, bus_if.rsp_err, bus_if.rsp_rdata); end
        @(negedge clk);
`else
        @(negedge clk);
        checks++; if ({sram_ceb, sram_web} !== 2'b01 || sram_addr !== 14'h0040) begin errors++; $display("FAIL ld_split b0: got %b %h want 01 0040", {sram_ceb, sram_web}, sram_addr); end
        @(negedge clk);
        checks++; if ({sram_ceb, sram_web} !== 2'b01 || sram_addr !== 14'h0041) begin errors++; $display("FAIL ld_split b1: got %b %h want 01 0041", {sram_ceb, sram_web}, sram_addr); end
        @(negedge clk);
        checks++; if (bus_if.rsp_valid !== 1'b1 || bus_if.rsp_rdata !== 32'h6655_4433 || bus_if.rsp_err !== 1'b0) begin errors++; $display("FAIL ld_split rsp: got %b %h %b want 1 66554433 0", bus_if.rsp_valid, bus_if.rsp_rdata, bus_if.rsp_err); end
        @(negedge clk);
`endif
    endtask

    task automatic test_reset_mid;
        preload(14'h003F, 32'h5555_5555);
        preload(14'h0040, 32'h6666_6666);
`ifdef DM_MISALIGN_TRAP_EN
        send(1'b1, 2'd2, 1'b0, 32'h0000_0100, 32'h1234_5678, 1'b0);
`else
        send(1'b1, 2'd1, 1'b0, 32'h0000_00FF, 32'h0000_ABCD, 1'b0);
`endif
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++; if (sram_ceb !== 1'b1 || sram_web !== 1'b1 || sram_bweb !== 32'hFFFF_FFFF) begin errors++; $display("FAIL rst_mid sram idle: got %b %b %h want 1 1 ffffffff", sram_ceb, sram_web, sram_bweb); end
        checks++; if (sram_addr !== '0 || sram_din !== 32'd0 || bus_if.req_ready !== 1'b0) begin errors++; $display("FAIL rst_mid addr/din/ready: got %h %h %b want 0 0 0", sram_addr, sram_din, bus_if.req_ready); end
        @(negedge clk);
        checks++; if (sram_ceb !== 1'b1 || bus_if.rsp_valid !== 1'b0) begin errors++; $display("FAIL rst_mid held: got ceb %b valid %b want 1 0", sram_ceb, bus_if.rsp_valid); end
        rst = 1'b0;
        #1;
        checks++; if (bus_if.req_ready !== 1'b1) begin errors++; $display("FAIL rst_mid ready after: got %b want 1", bus_if.req_ready); end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++; if (bus_if.rsp_valid !== 1'b0 || sram_ceb !== 1'b1) begin errors++; $display("FAIL rst_mid quiet %0d: got valid %b ceb %b want 0 1", i, bus_if.rsp_valid, sram_ceb); end
        end
        checks++; if (mem[14'h003F] !== 32'h5555_5555 || mem[14'h0040] !== 32'h6666_6666) begin errors++; $display("FAIL rst_mid mem: got %h %h want 55555555 66666666", mem[14'h003F], mem[14'h0040]); end
    endtask

    task automatic test_wrap;
        preload(14'h3FFF, 32'hAA00_0000);
        preload(14'h0000, 32'h0000_00BB);
        send(1'b0, 2'd1, 1'b1, 32'h0000_FFFF, 32'd0, 1'b0);
`ifdef DM_MISALIGN_TRAP_EN
        @(negedge clk);
        checks++; if (sram_ceb !== 1'b1 || bus_if.rsp_valid !== 1'b1 || bus_if.rsp_err !== 1'b1) begin errors++; $display("FAIL wrap trap: got ceb %b valid %b err %b want 1 1 1", sram_ceb, bus_if.rsp_valid, bus_if.rsp_err); end
        @(negedge clk);
`else
        @(negedge clk);
        checks++; if (sram_ceb !== 1'b0 || sram_addr !== 14'h3FFF) begin errors++; $display("FAIL wrap b0: got %b %h want 0 3fff", sram_ceb, sram_addr); end
        @(negedge clk);
        checks++; if (sram_ceb !== 1'b0 || sram_addr !== 14'h0000) begin errors++; $display("FAIL wrap b1: got %b %h want 0 0000", sram_ceb, sram_addr); end
        @(negedge clk);
        checks++; if (bus_if.rsp_valid !== 1'b1 || bus_if.rsp_rdata !== 32'h0000_BBAA) begin errors++; $display("FAIL wrap rsp: got %b %h want 1 0000bbaa", bus_if.rsp_valid, bus_if.rsp_rdata); end
        @(negedge clk);
`endif
    endtask

    task automatic test_back_to_back;
        send(1'b1, 2'd2, 1'b0, 32'h0000_0200, 32'hA1B2_C3D4, 1'b1);
        bus_if.req_write    = 1'b0;
        bus_if.req_size     = 2'd0;
        bus_if.req_unsigned = 1'b0;
        bus_if.req_addr     = 32'h0000_0201;
        bus_if.req_wdata    = 32'd0;
        @(negedge clk);
        checks++; if (sram_web !== 1'b0 || sram_addr !== 14'h0080 || sram_din !== 32'hA1B2_C3D4) begin errors++; $display("FAIL b2b st beat: got web %b addr %h din %h want 0 0080 a1b2c3d4", sram_web, sram_addr, sram_din); end
        checks++; if (bus_if.req_ready !== 1'b0) begin errors++; $display("FAIL b2b ready beat: got %b want 0", bus_if.req_ready); end
        @(negedge clk);
        checks++; if (bus_if.rsp_valid !== 1'b1 || bus_if.req_ready !== 1'b0) begin errors++; $display("FAIL b2b fin: got valid %b ready %b want 1 0", bus_if.rsp_valid, bus_if.req_ready); end
        @(negedge clk);
        checks++; if (bus_if.req_ready !== 1'b1 || bus_if.rsp_valid !== 1'b0) begin errors++; $display("FAIL b2b idle: got ready %b valid %b want 1 0", bus_if.req_ready, bus_if.rsp_valid); end
        @(posedge clk);
        #1 bus_if.req_valid = 1'b0;
        @(negedge clk);
        checks++; if ({sram_ceb, sram_web} !== 2'b01 || sram_addr !== 14'h0080) begin errors++; $display("FAIL b2b ld beat: got %b %h want 01 0080", {sram_ceb, sram_web}, sram_addr); end
        @(negedge clk);
        checks++; if (bus_if.rsp_valid !== 1'b1 || bus_if.rsp_rdata !== 32'hFFFF_FFC3) begin errors++; $display("FAIL b2b ld rsp: got %b %h want 1 ffffffc3", bus_if.rsp_valid, bus_if.rsp_rdata); end
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        pl_en = 1'b0;
        pl_addr = '0;
        pl_data = 32'd0;
        bus_if.req_valid    = 1'b0;
        bus_if.req_write    = 1'b0;
        bus_if.req_size     = 2'd0;
        bus_if.req_unsigned = 1'b0;
        bus_if.req_addr     = 32'd0;
        bus_if.req_wdata    = 32'd0;
        test_reset();
        test_word_store();
        test_byte_load();
        test_half_store_masked();
        test_split_store();
        test_split_load();
        test_reset_mid();
        test_wrap();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dm_access_ctrl.md
Name: dm_access_ctrl

Overview:
- Sequences load/store requests from the MEM stage onto the single-port synchronous data SRAM (1-cycle read latency, active-low CEB/WEB/BWEB).
- Handles byte-lane steering, store masking, load sign/zero extension and misaligned accesses; a misaligned access that crosses a word boundary is split into two aligned SRAM beats.
- Sits between the pipeline's MEM stage and the DM macro, and replaces direct LSU-to-SRAM wiring.
- The stall signal for the pipeline is derived from req_ready.

Parameters:
- ADDR_W, 14, SRAM word-address width. Byte address bits [ADDR_W+1:2] are used; upper bits are ignored.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous active-high reset
- req_valid  in  1  access request
- req_ready  out  1  controller can accept; high only in IDLE with rst low
- req_write  in  1  1=store, 0=load
- req_size  in  2  0=byte, 1=half, 2=word, 3=reserved (treated as word)
- req_unsigned  in  1  zero-extend load (LBU/LHU)
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-aligned
- rsp_valid  out  1  one-cycle pulse: access complete
- rsp_rdata  out  32  extended load data; 0 for stores
- rsp_err  out  1  misalignment error (see Optional Feature)
- sram_ceb  out  1  chip enable, active low
- sram_web  out  1  write enable, active low
- sram_bweb  out  32  per-bit write mask, 0 = write bit
- sram_addr  out  ADDR_W  word address
- sram_din  out  32  write data
- sram_dout  in  32  read data, valid the cycle after a read beat

Behaviour:
- Reset (synchronous, rst high):
  - State goes to IDLE; all request/beat registers clear.
  - While rst is high: rsp_valid=0, rsp_rdata=0, rsp_err=0, req_ready=0, sram_ceb=1, sram_web=1, sram_bweb=all ones, sram_addr=0, sram_din=0.
  - Reset mid-operation aborts the access. No further beat is issued, and no response is produced for the aborted request.
- States: IDLE, BEAT0, BEAT1, FIN.
- IDLE:
  - req_ready=1.
  - On req_valid, capture the request and compute:
    - off = addr[1:0]
    - wa = addr[ADDR_W+1:2]
    - nbytes = 1, 2 or 4
    - split = (off + nbytes > 4)
  - Next state is BEAT0.
- BEAT0:
  - Drive sram_ceb=0 and sram_addr=wa.
  - Store: sram_web=0, sram_din=lane64[31:0], sram_bweb=~mask64[31:0].
  - lane64 = zero-extended wdata << 8*off. mask64 = nbytes ones-bytes << 8*off.
  - Next state is BEAT1 if split, else FIN.
- BEAT1:
  - Drive sram_addr=wa+1, wrapping modulo 2^ADDR_W; sram_din=lane64[63:32]; sram_bweb=~mask64[63:32].
  - Load: register sram_dout (beat0 data) into lo_buf.
  - Next state is FIN.
- FIN:
  - No SRAM access (ceb=1). Pulse rsp_valid=1 for one cycle.
  - Load: rd64 = split ? {sram_dout, lo_buf} : {32'd0, sram_dout}. Then sel = rd64 >> 8*off; the low nbytes are sign- or zero-extended to 32 bits.
  - Store: rsp_rdata=0.
  - Next state is IDLE.
- Outside beats, SRAM outputs hold their idle values: ceb=1, web=1, bweb=all ones, addr=0, din=0.
- Latency from the accept edge: non-split rsp_valid at T+2; split at T+3.
- Next request is accepted at T+3 (non-split) or T+4 (split), one cycle after FIN.
- Little-endian byte order throughout. An access never writes lanes outside the mask.
- req_valid while req_ready=0 is ignored. The requester holds req_valid until accepted.
- Request fields are sampled only at accept; later changes have no effect.

Optional Feature:
- Macro DM_MISALIGN_TRAP_EN.
- Defined:
  - Any access with off not a multiple of nbytes is rejected.
  - Rejection means no SRAM beat, IDLE→FIN directly, and rsp_valid=1 with rsp_err=1 and rsp_rdata=0 at T+1.
  - Aligned accesses are unchanged; the split path never occurs.
- Undefined:
  - Misaligned accesses are split or handled as above.
  - rsp_err is tied to 0.

Test Plan:
1. Word store, addr 0x100, wdata 0xDEADBEEF:
   - T+1: ceb=0, web=0, addr=0x40, bweb=0x00000000, din=0xDEADBEEF.
   - T+2: rsp_valid=1, rdata=0.
2. Signed byte load, addr 0x103, mem[0x40]=0x80112233:
   - T+2: rsp_rdata=0xFFFFFF80.
   - Same access with req_unsigned=1: rsp_rdata=0x00000080.
3. Half store, addr 0x0FF, wdata 0x0000ABCD (macro undefined):
   - Beat0: addr 0x3F, bweb 0x00FFFFFF, din 0xCD000000.
   - Beat1: addr 0x40, bweb 0xFFFFFF00, din 0x000000AB.
   - rsp_valid at T+3.
4. Word load, addr 0x102, mem[0x40]=0x44332211, mem[0x41]=0x88776655:
   - Two read beats; rsp_rdata=0x66554433 at T+3.
   - With DM_MISALIGN_TRAP_EN: no beat, rsp_err=1 at T+1.
5. Reset asserted during BEAT0 of the split store from scenario 3:
   - No beat1 write, no rsp_valid, SRAM idle values during reset.
   - req_ready=1 on the first cycle after rst deasserts.
6. Wrap, unsigned half load, addr 0x0000FFFF (ADDR_W=14):
   - Beat0 at word addr 0x3FFF, beat1 at word addr 0x0000.
   - mem[0x3FFF]=0xAA000000, mem[0]=0x000000BB: rsp_rdata=0x0000BBAA.
